// File: rtl/pcie_status_mon_amm.sv
// PCIe link-status monitor: samples HIP status of NR_LINKS cores, keeps per-link
// LTSSM-transition, link-down and uptime counters, and raises a maskable link-down IRQ.
module pcie_status_mon_amm #(
  parameter int NR_LINKS = 1,
  parameter int ADDR_W   = 6
) (
  input  logic                  clk,
  input  logic                  rsi_reset_reset_n,
  input  logic [ADDR_W-1:0]     avs_ctrl_address,
  input  logic                  avs_ctrl_read,
  output logic [31:0]           avs_ctrl_readdata,
  input  logic                  avs_ctrl_write,
  input  logic [31:0]           avs_ctrl_writedata,
  output logic                  ins_irq_irq,
  input  logic [2*NR_LINKS-1:0] hip_currentspeed_currentspeed,
  input  logic [5*NR_LINKS-1:0] hip_status_ltssmstate,
  input  logic [4*NR_LINKS-1:0] hip_status_lane_act,
  input  logic [NR_LINKS-1:0]   hip_status_dlup
);

  localparam logic [31:0] ID_VAL      = 32'h2c1e57a8;
  localparam logic [31:0] VERSION_VAL = 32'h00020000;
  localparam logic [31:0] CNT_MAX     = 32'hFFFFFFFF;
  localparam logic [31:0] BAD_ADDR    = 32'hdeadbeef;

  logic [31:0]            w_addr;
  logic                   w_evt_en;
  logic [1:0]             r_warm;
  logic [NR_LINKS-1:0]    w_down_evt;
  logic [NR_LINKS-1:0]    w_clr;
  logic [NR_LINKS-1:0]    w_w1c;
  logic [NR_LINKS-1:0]    r_irq_status;
  logic [NR_LINKS-1:0]    r_irq_mask;
  logic [32*NR_LINKS-1:0] w_status_flat;
  logic [32*NR_LINKS-1:0] w_ltssm_flat;
  logic [32*NR_LINKS-1:0] w_down_flat;
  logic [32*NR_LINKS-1:0] w_up_flat;
  logic [31:0]            w_rdata;
  logic                   w_unused;

  assign w_addr   = 32'(avs_ctrl_address);
  assign w_evt_en = (r_warm == 2'd3);
  assign w_w1c    = (avs_ctrl_write && w_addr == 32'd3) ? avs_ctrl_writedata[NR_LINKS-1:0] : '0;
  assign w_unused = ^avs_ctrl_writedata;

  genvar gi;
  generate
    for (gi = 0; gi < NR_LINKS; gi++) begin : gen_link
      logic [31:0] r_st1;
      logic [31:0] r_st_s;
      logic [31:0] r_st_p;
      logic [31:0] r_ltssm_cnt;
      logic [31:0] r_down_cnt;
      logic [31:0] r_uptime;
      logic        w_ltssm_evt;
      logic        w_rise;
      logic        w_unused_p;

      assign w_ltssm_evt     = w_evt_en && (r_st_s[12:8] != r_st_p[12:8]);
      assign w_rise          = w_evt_en && r_st_s[24] && !r_st_p[24];
      assign w_down_evt[gi]  = w_evt_en && r_st_p[24] && !r_st_s[24];
      assign w_clr[gi]       = avs_ctrl_write && avs_ctrl_writedata[0] &&
                               (w_addr == 32'(12 + 8*gi));
      assign w_unused_p      = ^{r_st_p[31:25], r_st_p[23:13], r_st_p[7:0]};

      assign w_status_flat[32*gi +: 32] = r_st_s;
      assign w_ltssm_flat[32*gi +: 32]  = r_ltssm_cnt;
      assign w_down_flat[32*gi +: 32]   = r_down_cnt;
      assign w_up_flat[32*gi +: 32]     = r_uptime;

      always_ff @(posedge clk) begin
        if (!rsi_reset_reset_n) begin
          r_st1       <= '0;
          r_st_s      <= '0;
          r_st_p      <= '0;
          r_ltssm_cnt <= '0;
          r_down_cnt  <= '0;
          r_uptime    <= '0;
        end else begin
          r_st1  <= {7'd0, hip_status_dlup[gi], 4'd0, hip_status_lane_act[4*gi +: 4],
                     3'd0, hip_status_ltssmstate[5*gi +: 5], 6'd0,
                     hip_currentspeed_currentspeed[2*gi +: 2]};
          r_st_s <= r_st1;
          r_st_p <= r_st_s;
          // A clear swallows any event landing in the same cycle.
          if (w_clr[gi]) begin
            r_ltssm_cnt <= '0;
            r_down_cnt  <= '0;
            r_uptime    <= '0;
          end else begin
            if (w_ltssm_evt && r_ltssm_cnt != CNT_MAX) r_ltssm_cnt <= r_ltssm_cnt + 32'd1;
            if (w_down_evt[gi] && r_down_cnt != CNT_MAX) r_down_cnt <= r_down_cnt + 32'd1;
            if (w_rise) r_uptime <= '0;
            else if (w_evt_en && r_st_s[24] && r_uptime != CNT_MAX) r_uptime <= r_uptime + 32'd1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_rdata = BAD_ADDR;
    case (w_addr)
      32'd0:   w_rdata = ID_VAL;
      32'd1:   w_rdata = VERSION_VAL;
      32'd2:   w_rdata = 32'(NR_LINKS);
      32'd3:   w_rdata = 32'(r_irq_status);
      32'd4:   w_rdata = 32'(r_irq_mask);
      default: w_rdata = BAD_ADDR;
    endcase
    for (int i = 0; i < NR_LINKS; i++) begin
      if (w_addr == 32'(8 + 8*i))  w_rdata = w_status_flat[32*i +: 32];
      if (w_addr == 32'(9 + 8*i))  w_rdata = w_ltssm_flat[32*i +: 32];
      if (w_addr == 32'(10 + 8*i)) w_rdata = w_down_flat[32*i +: 32];
      if (w_addr == 32'(11 + 8*i)) w_rdata = w_up_flat[32*i +: 32];
      if (w_addr == 32'(12 + 8*i)) w_rdata = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rsi_reset_reset_n) begin
      r_warm            <= '0;
      r_irq_status      <= '0;
      r_irq_mask        <= '0;
      ins_irq_irq       <= 1'b0;
      avs_ctrl_readdata <= '0;
    end else begin
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
      // New link-down wins over a same-cycle write-1-to-clear.
      r_irq_status <= w_down_evt | (r_irq_status & ~w_w1c);
      if (avs_ctrl_write && w_addr == 32'd4) r_irq_mask <= avs_ctrl_writedata[NR_LINKS-1:0];
      ins_irq_irq <= |(r_irq_status & r_irq_mask);
      if (avs_ctrl_read) avs_ctrl_readdata <= w_rdata;
    end
  end

endmodule

// File: tb/tb_pcie_status_mon_amm.sv
// Directed self-checking bench for pcie_status_mon_amm with two monitored links.
module tb_pcie_status_mon_amm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  speed;
  logic [9:0]  ltssm;
  logic [7:0]  lanes;
  logic [1:0]  dlup;

  int n_checks = 0;
  int n_fail   = 0;

  pcie_status_mon_amm #(.NR_LINKS(2), .ADDR_W(6)) dut (
    .clk                           (clk),
    .rsi_reset_reset_n             (rst_n),
    .avs_ctrl_address              (address),
    .avs_ctrl_read                 (read),
    .avs_ctrl_readdata             (readdata),
    .avs_ctrl_write                (write),
    .avs_ctrl_writedata            (writedata),
    .ins_irq_irq                   (irq),
    .hip_currentspeed_currentspeed (speed),
    .hip_status_ltssmstate         (ltssm),
    .hip_status_lane_act           (lanes),
    .hip_status_dlup               (dlup)
  );

  always #5 clk = ~clk;

  task automatic do_read(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d    = readdata;
    $display("read  addr=%0d data=%h", a, d);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic do_rw(input logic [5:0] a, input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    address   = a;
    writedata = wd;
    read      = 1'b1;
    write     = 1'b1;
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
    rd    = readdata;
    $display("rdwr  addr=%0d wdata=%h rdata=%h", a, wd, rd);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; read = 1'b1; write = 1'b0; address = 6'd0; writedata = '0;
    speed = 4'b0010; ltssm = {5'h00, 5'h11}; lanes = 8'h0F; dlup = 2'b01;
    repeat (4) @(negedge clk);
    n_checks++;
    if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_readdata: got %h want %h", readdata, 32'd0); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    read = 1'b0;
    rst_n = 1'b1;
    do_read(6'd0, d);
    n_checks++;
    if (d !== 32'h2c1e57a8) begin n_fail++; $display("FAIL id: got %h want %h", d, 32'h2c1e57a8); end
    do_read(6'd1, d);
    n_checks++;
    if (d !== 32'h00020000) begin n_fail++; $display("FAIL version: got %h want %h", d, 32'h00020000); end
    do_read(6'd2, d);
    n_checks++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL nr_links: got %h want %h", d, 32'd2); end
    do_read(6'd9, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ltssm_cnt0_reset: got %h want %h", d, 32'd0); end
    do_read(6'd24, d);
    n_checks++;
    if (d !== 32'hdeadbeef) begin n_fail++; $display("FAIL unmapped_24: got %h want %h", d, 32'hdeadbeef); end
    do_read(6'd13, d);
    n_checks++;
    if (d !== 32'hdeadbeef) begin n_fail++; $display("FAIL unmapped_13: got %h want %h", d, 32'hdeadbeef); end
    do_read(6'd12, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ctrl_reads_0: got %h want %h", d, 32'd0); end
  endtask

  task automatic test_status_word();
    logic [31:0] d;
    repeat (5) @(negedge clk);
    do_read(6'd8, d);
    n_checks++;
    if (d !== 32'h010F1102) begin n_fail++; $display("FAIL status0: got %h want %h", d, 32'h010F1102); end
    do_read(6'd9, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ltssm_cnt0_warmup: got %h want %h", d, 32'd0); end
    do_read(6'd10, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL down_cnt0_warmup: got %h want %h", d, 32'd0); end
    do_read(6'd3, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL irq_status_warmup: got %h want %h", d, 32'd0); end
    do_read(6'd16, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL status1_idle: got %h want %h", d, 32'd0); end
  endtask

  task automatic test_ltssm_count();
    logic [31:0] d;
    @(negedge clk); ltssm[9:5] = 5'h01;
    repeat (3) @(negedge clk); ltssm[9:5] = 5'h02;
    repeat (4) @(negedge clk); ltssm[9:5] = 5'h11;
    repeat (5) @(negedge clk);
    do_read(6'd17, d);
    n_checks++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL ltssm_cnt1_seq: got %h want %h", d, 32'd3); end
    do_read(6'd16, d);
    n_checks++;
    if (d !== 32'h00001100) begin n_fail++; $display("FAIL status1: got %h want %h", d, 32'h00001100); end
    do_write(6'd0, 32'h12345678);
    do_read(6'd0, d);
    n_checks++;
    if (d !== 32'h2c1e57a8) begin n_fail++; $display("FAIL id_ro: got %h want %h", d, 32'h2c1e57a8); end
    do_write(6'd20, 32'd1);
    do_read(6'd17, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ltssm_cnt1_clear: got %h want %h", d, 32'd0); end
    // transition reaches the comparator exactly on the clear cycle
    @(negedge clk); ltssm[9:5] = 5'h03;
    @(negedge clk);
    do_write(6'd20, 32'd1);
    do_read(6'd17, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ltssm_clear_race: got %h want %h", d, 32'd0); end
    @(negedge clk); ltssm[9:5] = 5'h04;
    repeat (5) @(negedge clk);
    do_read(6'd17, d);
    n_checks++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL ltssm_after_clear: got %h want %h", d, 32'd1); end
  endtask

  task automatic test_uptime_irq();
    logic [31:0] d;
    @(negedge clk); dlup[0] = 1'b0;
    repeat (5) @(negedge clk);
    do_write(6'd12, 32'd1);
    do_write(6'd3, 32'd1);
    do_read(6'd10, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL down_cnt0_clear: got %h want %h", d, 32'd0); end
    do_read(6'd3, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL irq_status_w1c: got %h want %h", d, 32'd0); end
    @(negedge clk); dlup[0] = 1'b1;
    repeat (100) @(negedge clk);
    dlup[0] = 1'b0;
    repeat (6) @(negedge clk);
    do_read(6'd11, d);
    n_checks++;
    if (d < 32'd98 || d > 32'd102) begin n_fail++; $display("FAIL uptime0: got %0d want 98..102", d); end
    repeat (20) @(negedge clk);
    do_read(6'd11, d);
    n_checks++;
    if (d < 32'd98 || d > 32'd102) begin n_fail++; $display("FAIL uptime0_hold: got %0d want 98..102", d); end
    do_read(6'd10, d);
    n_checks++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL down_cnt0: got %h want %h", d, 32'd1); end
    do_read(6'd3, d);
    n_checks++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL irq_status0: got %h want %h", d, 32'd1); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", irq); end
    do_write(6'd4, 32'd1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_unmasked: got %b want 1", irq); end
    do_rw(6'd4, 32'd0, d);
    n_checks++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL rw_prewrite: got %h want %h", d, 32'd1); end
    do_read(6'd4, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL mask_cleared: got %h want %h", d, 32'd0); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_remasked: got %b want 0", irq); end
    do_write(6'd4, 32'hFFFFFFFF);
    do_read(6'd4, d);
    n_checks++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL mask_upper_bits: got %h want %h", d, 32'd3); end
    do_write(6'd4, 32'd1);
    do_write(6'd3, 32'd1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_w1c: got %b want 0", irq); end
    do_read(6'd3, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL irq_status_after_w1c: got %h want %h", d, 32'd0); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    @(negedge clk); dlup[0] = 1'b1;
    repeat (6) @(negedge clk);
    // link-down reaches the comparator on the same cycle as the W1C write
    @(negedge clk); dlup[0] = 1'b0;
    @(negedge clk);
    do_write(6'd3, 32'd1);
    do_read(6'd3, d);
    n_checks++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL w1c_race_status: got %h want %h", d, 32'd1); end
    do_read(6'd10, d);
    n_checks++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL w1c_race_down_cnt: got %h want %h", d, 32'd2); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_race_irq: got %b want 1", irq); end
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    @(negedge clk);
    force dut.gen_link[1].r_ltssm_cnt = 32'hFFFFFFFE;
    @(negedge clk);
    release dut.gen_link[1].r_ltssm_cnt;
    @(negedge clk); ltssm[9:5] = 5'h05;
    repeat (4) @(negedge clk); ltssm[9:5] = 5'h06;
    repeat (4) @(negedge clk); ltssm[9:5] = 5'h07;
    repeat (5) @(negedge clk);
    do_read(6'd17, d);
    n_checks++;
    if (d !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL ltssm_saturate: got %h want %h", d, 32'hFFFFFFFF); end
    do_read(6'd18, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL down_cnt1: got %h want %h", d, 32'd0); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d;
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_before_reset: got %b want 1", irq); end
    @(negedge clk);
    address = 6'd0; read = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (readdata !== 32'd0) begin n_fail++; $display("FAIL midrun_readdata: got %h want %h", readdata, 32'd0); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL midrun_irq: got %b want 0", irq); end
    read = 1'b0; rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_read(6'd17, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL midrun_ltssm_cnt1: got %h want %h", d, 32'd0); end
    do_read(6'd10, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL midrun_down_cnt0: got %h want %h", d, 32'd0); end
    do_read(6'd11, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL midrun_uptime0: got %h want %h", d, 32'd0); end
    do_read(6'd3, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL midrun_irq_status: got %h want %h", d, 32'd0); end
    do_read(6'd4, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL midrun_irq_mask: got %h want %h", d, 32'd0); end
  endtask

  initial begin
    test_reset();
    test_status_word();
    test_ltssm_count();
    test_uptime_irq();
    test_w1c_race();
    test_saturation();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
